// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator (800x600 default): registered hsync/vsync, position, visible and start pulses.
// Optional frame counter output is enabled by defining VGA_FRAME_CNT_EN.
module vga_sync_gen #(
    parameter int unsigned HOR_Visible_Area = 800,
    parameter int unsigned HOR_Front_porch  = 40,
    parameter int unsigned HOR_Sync_pulse   = 128,
    parameter int unsigned HOR_Back_porch   = 88,
    parameter int unsigned HOR_TOTAL        = 1056,
    parameter int unsigned VER_Visible_Area = 600,
    parameter int unsigned VER_Front_porch  = 1,
    parameter int unsigned VER_Sync_pulse   = 4,
    parameter int unsigned VER_Back_porch   = 23,
    parameter int unsigned VER_TOTAL        = 628
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] display_col,
    output logic [10:0] display_row,
    output logic        visible,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNC, H_BACK} h_state_t;
    typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNC, V_BACK} v_state_t;

    localparam int unsigned H_SUM = HOR_Visible_Area + HOR_Front_porch + HOR_Sync_pulse + HOR_Back_porch;
    localparam int unsigned V_SUM = VER_Visible_Area + VER_Front_porch + VER_Sync_pulse + VER_Back_porch;

    // Last position is bounded by both the declared total and the porch sum.
    localparam logic [11:0] H_LAST     = 12'(((HOR_TOTAL < H_SUM) ? HOR_TOTAL : H_SUM) - 1);
    localparam logic [11:0] H_FP_START = 12'(HOR_Visible_Area);
    localparam logic [11:0] H_SY_START = 12'(HOR_Visible_Area + HOR_Front_porch);
    localparam logic [11:0] H_BP_START = 12'(HOR_Visible_Area + HOR_Front_porch + HOR_Sync_pulse);
    localparam logic [10:0] V_LAST     = 11'(((VER_TOTAL < V_SUM) ? VER_TOTAL : V_SUM) - 1);
    localparam logic [10:0] V_FP_START = 11'(VER_Visible_Area);
    localparam logic [10:0] V_SY_START = 11'(VER_Visible_Area + VER_Front_porch);
    localparam logic [10:0] V_BP_START = 11'(VER_Visible_Area + VER_Front_porch + VER_Sync_pulse);

    h_state_t    h_state, h_nx;
    v_state_t    v_state, v_nx;
    logic [11:0] col_nx;
    logic [10:0] row_nx;
    logic        hsync_nx, vsync_nx, visible_nx, ls_nx, fs_nx;
    logic        col_wrap, row_wrap;

    // An out-of-range row also forces the column to wrap, so the frame restarts at (0,0).
    assign row_wrap = (display_row >= V_LAST);
    assign col_wrap = (display_col >= H_LAST) || (display_row > V_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            display_col <= H_LAST;
            display_row <= V_LAST;
            h_state     <= H_BACK;
            v_state     <= V_BACK;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            visible     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            display_col <= col_nx;
            display_row <= row_nx;
            h_state     <= h_nx;
            v_state     <= v_nx;
            hsync       <= hsync_nx;
            vsync       <= vsync_nx;
            visible     <= visible_nx;
            line_start  <= ls_nx;
            frame_start <= fs_nx;
        end
    end

    // Phases are decoded from the position being loaded so sync/visible share its edge.
    always_comb begin
        col_nx     = display_col;
        row_nx     = display_row;
        h_nx       = h_state;
        v_nx       = v_state;
        hsync_nx   = hsync;
        vsync_nx   = vsync;
        visible_nx = visible;
        ls_nx      = 1'b0;
        fs_nx      = 1'b0;
        if (enable) begin
            if (col_wrap) begin
                col_nx = '0;
                ls_nx  = 1'b1;
                if (row_wrap) begin
                    row_nx = '0;
                    fs_nx  = 1'b1;
                end else begin
                    row_nx = display_row + 11'd1;
                end
                if (row_nx < V_FP_START)      v_nx = V_ACTIVE;
                else if (row_nx < V_SY_START) v_nx = V_FRONT;
                else if (row_nx < V_BP_START) v_nx = V_SYNC;
                else                          v_nx = V_BACK;
            end else begin
                col_nx = display_col + 12'd1;
            end
            if (col_nx < H_FP_START)      h_nx = H_ACTIVE;
            else if (col_nx < H_SY_START) h_nx = H_FRONT;
            else if (col_nx < H_BP_START) h_nx = H_SYNC;
            else                          h_nx = H_BACK;
            hsync_nx   = (h_nx == H_SYNC);
            vsync_nx   = (v_nx == V_SYNC);
            visible_nx = (h_nx == H_ACTIVE) && (v_nx == V_ACTIVE);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (fs_nx) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size instance for line timing, small instance for frame timing.
module tb_vga_sync_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        d_hs, d_vs, d_vis, d_ls, d_fs;
    logic [11:0] d_col;
    logic [10:0] d_row;
    logic        s_hs, s_vs, s_vis, s_ls, s_fs;
    logic [11:0] s_col;
    logic [10:0] s_row;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] d_fc, s_fc;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    vga_sync_gen u_full (
        .clock(clock), .reset(reset), .enable(enable),
        .hsync(d_hs), .vsync(d_vs), .display_col(d_col), .display_row(d_row),
        .visible(d_vis), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(d_fc)
`endif
    );

    // 16 pixels x 12 lines: H 10/2/3/1, V 6/1/2/3.
    vga_sync_gen #(
        .HOR_Visible_Area(10), .HOR_Front_porch(2), .HOR_Sync_pulse(3), .HOR_Back_porch(1), .HOR_TOTAL(16),
        .VER_Visible_Area(6), .VER_Front_porch(1), .VER_Sync_pulse(2), .VER_Back_porch(3), .VER_TOTAL(12)
    ) u_small (
        .clock(clock), .reset(reset), .enable(enable),
        .hsync(s_hs), .vsync(s_vs), .display_col(s_col), .display_row(s_row),
        .visible(s_vis), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(s_fc)
`endif
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        enable = 1'b0;
        reset  = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic advance_d(input int target);
        for (int i = 0; i < 1200 && int'(d_col) != target; i++) step();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({d_col, d_row, d_vis, d_fs, d_ls, d_hs, d_vs} !== {12'd1055, 11'd627, 5'b0}) begin
            n_bad++;
            $display("FAIL reset_full: got col=%0d row=%0d vis/fs/ls/hs/vs=%b%b%b%b%b, expected col=1055 row=627 00000",
                     d_col, d_row, d_vis, d_fs, d_ls, d_hs, d_vs);
        end
        n_cmp++;
        if ({s_col, s_row, s_vis, s_fs, s_ls, s_hs, s_vs} !== {12'd15, 11'd11, 5'b0}) begin
            n_bad++;
            $display("FAIL reset_small: got col=%0d row=%0d vis/fs/ls/hs/vs=%b%b%b%b%b, expected col=15 row=11 00000",
                     s_col, s_row, s_vis, s_fs, s_ls, s_hs, s_vs);
        end
`ifdef VGA_FRAME_CNT_EN
        n_cmp++;
        if (d_fc !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_frame_count: got %0d expected 0", d_fc);
        end
`endif
        enable = 1'b1;
        step();
        n_cmp++;
        if ({d_col, d_row, d_vis, d_fs, d_ls, d_hs, d_vs} !== {12'd0, 11'd0, 5'b11100}) begin
            n_bad++;
            $display("FAIL first_edge: got col=%0d row=%0d vis/fs/ls/hs/vs=%b%b%b%b%b, expected col=0 row=0 11100",
                     d_col, d_row, d_vis, d_fs, d_ls, d_hs, d_vs);
        end
        n_cmp++;
        if ({s_col, s_row, s_vis, s_fs, s_ls} !== {12'd0, 11'd0, 3'b111}) begin
            n_bad++;
            $display("FAIL first_edge_small: got col=%0d row=%0d vis/fs/ls=%b%b%b, expected 0 0 111",
                     s_col, s_row, s_vis, s_fs, s_ls);
        end
`ifdef VGA_FRAME_CNT_EN
        n_cmp++;
        if (d_fc !== 16'd1) begin
            n_bad++;
            $display("FAIL first_frame_count: got %0d expected 1", d_fc);
        end
`endif
        step();
        n_cmp++;
        if ({d_col, d_row, d_vis, d_fs, d_ls} !== {12'd1, 11'd0, 3'b100}) begin
            n_bad++;
            $display("FAIL second_edge: got col=%0d row=%0d vis/fs/ls=%b%b%b, expected col=1 row=0 100",
                     d_col, d_row, d_vis, d_fs, d_ls);
        end
    endtask

    task automatic test_line();
        int hs_rise = -1, hs_fall = -1, vis_fall = -1, max_col = 0, nls = 0;
        int ls_t0 = 0, ls_t1 = 0;
        logic prev_hs, prev_vis;
        prev_hs  = d_hs;
        prev_vis = d_vis;
        for (int i = 1; i <= 2200 && nls < 2; i++) begin
            step();
            if (d_hs && !prev_hs && hs_rise < 0) hs_rise = int'(d_col);
            if (!d_hs && prev_hs && hs_fall < 0) hs_fall = int'(d_col);
            if (!d_vis && prev_vis && vis_fall < 0) vis_fall = int'(d_col);
            if (int'(d_col) > max_col) max_col = int'(d_col);
            if (d_ls) begin
                if (nls == 0) ls_t0 = i; else ls_t1 = i;
                nls++;
            end
            prev_hs  = d_hs;
            prev_vis = d_vis;
        end
        n_cmp++;
        if (hs_rise != 840) begin n_bad++; $display("FAIL hsync_rise_col: got %0d expected 840", hs_rise); end
        n_cmp++;
        if (hs_fall != 968) begin n_bad++; $display("FAIL hsync_fall_col: got %0d expected 968", hs_fall); end
        n_cmp++;
        if (vis_fall != 800) begin n_bad++; $display("FAIL visible_fall_col: got %0d expected 800", vis_fall); end
        n_cmp++;
        if (nls != 2 || ls_t0 != 1055 || ls_t1 - ls_t0 != 1056) begin
            n_bad++;
            $display("FAIL line_period: got pulses=%0d first=%0d period=%0d expected 2 1055 1056", nls, ls_t0, ls_t1 - ls_t0);
        end
        n_cmp++;
        if (max_col != 1055) begin n_bad++; $display("FAIL max_col: got %0d expected 1055", max_col); end
        n_cmp++;
        if ({d_row, d_col, d_vs} !== {11'd2, 12'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL row_after_two_lines: got row=%0d col=%0d vs=%b expected row=2 col=0 vs=0", d_row, d_col, d_vs);
        end
    endtask

    task automatic test_enable_hold();
        advance_d(10);
        step();
        n_cmp++;
        if (d_col !== 12'd11) begin n_bad++; $display("FAIL enable_pre: got col=%0d expected 11", d_col); end
        enable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++;
            if ({d_col, d_hs, d_vis} !== {12'd11, 1'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL enable_hold_%0d: got col=%0d hs=%b vis=%b expected col=11 hs=0 vis=1", k, d_col, d_hs, d_vis);
            end
        end
        enable = 1'b1;
        step();
        n_cmp++;
        if (d_col !== 12'd12) begin n_bad++; $display("FAIL enable_resume: got col=%0d expected 12", d_col); end

        advance_d(1055);
        step();
        n_cmp++;
        if ({d_col, d_ls} !== {12'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL wrap_pulse: got col=%0d ls=%b expected col=0 ls=1", d_col, d_ls);
        end
        enable = 1'b0;
        step();
        n_cmp++;
        if ({d_col, d_ls, d_vis} !== {12'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL pulse_drop: got col=%0d ls=%b vis=%b expected col=0 ls=0 vis=1", d_col, d_ls, d_vis);
        end
        enable = 1'b1;
        advance_d(900);
        enable = 1'b0;
        step();
        step();
        n_cmp++;
        if ({d_col, d_hs, d_vis} !== {12'd900, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL hold_in_sync: got col=%0d hs=%b vis=%b expected col=900 hs=1 vis=0", d_col, d_hs, d_vis);
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_midline();
        advance_d(500);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({d_col, d_row, d_vis, d_fs, d_ls, d_hs, d_vs} !== {12'd1055, 11'd627, 5'b0}) begin
            n_bad++;
            $display("FAIL async_reset: got col=%0d row=%0d vis/fs/ls/hs/vs=%b%b%b%b%b expected 1055 627 00000",
                     d_col, d_row, d_vis, d_fs, d_ls, d_hs, d_vs);
        end
        step();
        n_cmp++;
        if ({d_col, d_row, d_fs} !== {12'd1055, 11'd627, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_over_enable: got col=%0d row=%0d fs=%b expected 1055 627 0", d_col, d_row, d_fs);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if ({d_col, d_row, d_vis, d_fs, d_ls, d_hs, d_vs} !== {12'd0, 11'd0, 5'b11100}) begin
            n_bad++;
            $display("FAIL reset_recovery: got col=%0d row=%0d vis/fs/ls/hs/vs=%b%b%b%b%b expected 0 0 11100",
                     d_col, d_row, d_vis, d_fs, d_ls, d_hs, d_vs);
        end
    endtask

    task automatic test_small_frame();
        int vis_cnt = 0, vs_cnt = 0, ls_cnt = 0, fs_cnt = 0, vs_rises = 0, vs_aligned = 0;
        int vs_rise_row = -1, hs_rise = -1, hs_fall = -1, max_row = 0, max_col = 0;
        int fs_t[3];
        logic prev_vs, prev_hs;
        apply_reset();
        enable  = 1'b1;
        prev_vs = s_vs;
        prev_hs = s_hs;
        for (int i = 0; i < 576; i++) begin
            step();
            if (s_vis) vis_cnt++;
            if (s_vs) vs_cnt++;
            if (s_ls) ls_cnt++;
            if (s_vs && !prev_vs) begin
                vs_rises++;
                if (s_ls && s_col == 12'd0) vs_aligned++;
                if (vs_rise_row < 0) vs_rise_row = int'(s_row);
            end
            if (s_hs && !prev_hs && hs_rise < 0) hs_rise = int'(s_col);
            if (!s_hs && prev_hs && hs_fall < 0) hs_fall = int'(s_col);
            if (int'(s_row) > max_row) max_row = int'(s_row);
            if (int'(s_col) > max_col) max_col = int'(s_col);
            if (s_fs) begin
                if (fs_cnt < 3) fs_t[fs_cnt] = i;
                fs_cnt++;
`ifdef VGA_FRAME_CNT_EN
                n_cmp++;
                if (s_fc !== 16'(fs_cnt)) begin
                    n_bad++;
                    $display("FAIL frame_count_step: got %0d expected %0d", s_fc, fs_cnt);
                end
`endif
            end
            prev_vs = s_vs;
            prev_hs = s_hs;
        end
        n_cmp++;
        if (vis_cnt != 180) begin n_bad++; $display("FAIL visible_count: got %0d expected 180", vis_cnt); end
        n_cmp++;
        if (vs_cnt != 96) begin n_bad++; $display("FAIL vsync_width: got %0d expected 96", vs_cnt); end
        n_cmp++;
        if (ls_cnt != 36) begin n_bad++; $display("FAIL line_count: got %0d expected 36", ls_cnt); end
        n_cmp++;
        if (fs_cnt != 3 || fs_t[0] != 0 || fs_t[1] != 192 || fs_t[2] != 384) begin
            n_bad++;
            $display("FAIL frame_period: got n=%0d t=%0d,%0d,%0d expected 3 at 0,192,384", fs_cnt, fs_t[0], fs_t[1], fs_t[2]);
        end
        n_cmp++;
        if (vs_rise_row != 7 || vs_rises != 3 || vs_aligned != 3) begin
            n_bad++;
            $display("FAIL vsync_rise: got row=%0d rises=%0d aligned=%0d expected 7 3 3", vs_rise_row, vs_rises, vs_aligned);
        end
        n_cmp++;
        if (hs_rise != 12 || hs_fall != 15) begin
            n_bad++;
            $display("FAIL small_hsync: got rise=%0d fall=%0d expected 12 15", hs_rise, hs_fall);
        end
        n_cmp++;
        if (max_row != 11 || max_col != 15) begin
            n_bad++;
            $display("FAIL small_bounds: got row=%0d col=%0d expected 11 15", max_row, max_col);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_enable_hold();
        test_reset_midline();
        test_small_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
